// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among NREQ requesters.
// A requester holds req plus mode/a/b; the arbiter captures the winner's
// operands, launches the unit, waits for its done pulse and hands the result
// back to the winner with a one-cycle ready pulse.
//
// Handshake: req_i[k] is a level held by requester k until it sees
// ready_o[k]; ready_o is a one-cycle pulse qualifying res_o. Toward the unit,
// unit_start_o is a one-cycle launch and unit_done_i a one-cycle completion
// qualifying unit_res_i; done outside WAIT is ignored. All outputs are
// registered. state_o mirrors the FSM state for observation.
module addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   mode_i,
  input  logic [NREQ*W-1:0] a_i,
  input  logic [NREQ*W-1:0] b_i,
  output logic [NREQ-1:0]   ready_o,
  output logic [W-1:0]      res_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              unit_start_o,
  output logic              unit_mode_o,
  output logic [W-1:0]      unit_a_o,
  output logic [W-1:0]      unit_b_o,
  input  logic              unit_done_i,
  input  logic [W-1:0]      unit_res_i,
  output logic [2:0]        state_o
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ARB     = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] grant_d, ready_d;
  logic            busy_d, start_d, mode_d;
  logic [W-1:0]    a_d, b_d, res_d;

  logic            found;
  logic [LW-1:0]   win;
  logic [LW-1:0]   cand;

  assign state_o = state_q;

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = LW'((int'(last_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_o;
    ready_d = '0;
    start_d = 1'b0;
    mode_d  = unit_mode_o;
    a_d     = unit_a_o;
    b_d     = unit_b_o;
    res_d   = res_o;
    case (state_q)
      ARB: begin
        grant_d = '0;
        if (found) begin
          state_d      = ISSUE;
          last_d       = win;
          grant_d[win] = 1'b1;
          mode_d       = mode_i[win];
          a_d          = a_i[win*W +: W];
          b_d          = b_i[win*W +: W];
          start_d      = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (unit_done_i) begin
          res_d   = unit_res_i;
          ready_d = grant_o;
          state_d = DONE;
        end
      end
      DONE: begin
        // Drop grant for the release cycle so a stale req cannot be re-granted.
        grant_d = '0;
        state_d = RELEASE;
      end
      RELEASE: state_d = ARB;
      default: begin
        grant_d = '0;
        state_d = ARB;
      end
    endcase
    busy_d = (state_d != ARB);
  end

  // State, pointer and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ARB;
      last_q       <= LW'(NREQ - 1);
      grant_o      <= '0;
      ready_o      <= '0;
      busy_o       <= 1'b0;
      unit_start_o <= 1'b0;
      unit_mode_o  <= 1'b0;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
      res_o        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_o      <= grant_d;
      ready_o      <= ready_d;
      busy_o       <= busy_d;
      unit_start_o <= start_d;
      unit_mode_o  <= mode_d;
      unit_a_o     <= a_d;
      unit_b_o     <= b_d;
      res_o        <= res_d;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural add/sub unit,
// a ready-pulse monitor feeding a scoreboard, and a final report.
module tb_addsub_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int S_ARB = 0, S_ISSUE = 1, S_WAIT = 2;

  logic              clk_i, rst_i;
  logic [NREQ-1:0]   req_i, mode_i;
  logic [NREQ*W-1:0] a_i, b_i;
  logic [NREQ-1:0]   ready_o, grant_o;
  logic [W-1:0]      res_o, unit_a_o, unit_b_o, unit_res_i;
  logic              busy_o, unit_start_o, unit_mode_o, unit_done_i;
  logic [2:0]        state_o;

  addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .mode_i(mode_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .res_o(res_o),
    .grant_o(grant_o), .busy_o(busy_o), .unit_start_o(unit_start_o),
    .unit_mode_o(unit_mode_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_done_i(unit_done_i), .unit_res_i(unit_res_i), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0]    exp_q[$];
  logic [NREQ-1:0] exp_g_q[$];
  int cyc = 0;
  int n_ready = 0;
  int last_rdy_cyc = 0;
  int prev_rdy_cyc = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- unit model ----------------
  int unit_lat = 1;
  int cnt = -1;
  int spur_cnt = 0;
  int spur_seen = 0;
  logic [W-1:0] res_pend;

  // Done arrives unit_lat cycles after the first WAIT cycle; spurious pulses on request.
  initial begin
    unit_done_i = 1'b0;
    unit_res_i  = '0;
    res_pend    = '0;
    forever begin
      @(negedge clk_i);
      unit_done_i = 1'b0;
      if (spur_cnt != spur_seen) begin
        unit_done_i = 1'b1;
        unit_res_i  = 8'hEE;
        spur_seen++;
      end
      if (cnt == 0) begin
        unit_done_i = 1'b1;
        unit_res_i  = res_pend;
      end
      if (cnt >= 0) cnt--;
      if (unit_start_o) begin
        cnt      = unit_lat;
        res_pend = unit_mode_o ? unit_a_o + unit_b_o : unit_a_o - unit_b_o;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (ready_o != '0) begin
        check("rdy_vs_grant", ready_o, grant_o);
        check("rdy_after_done", unit_done_i, 1);
        if (exp_q.size() == 0) check("rdy_unexpected", ready_o, 0);
        else begin
          check("res", res_o, exp_q.pop_front());
          check("rdy_who", ready_o, exp_g_q.pop_front());
        end
        n_ready++;
        prev_rdy_cyc = last_rdy_cyc;
        last_rdy_cyc = cyc;
      end
      if (unit_start_o) check("start_width", prev_start, 0);
      prev_start = unit_start_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int k, input logic on, input logic m,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    req_i[k]         = on;
    mode_i[k]        = m;
    a_i[k*W +: W]    = a;
    b_i[k*W +: W]    = b;
  endtask

  task automatic expect_txn(input logic [W-1:0] r, input logic [NREQ-1:0] g);
    exp_q.push_back(r);
    exp_g_q.push_back(g);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, grant_o, 0);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_start"}, unit_start_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_state"}, state_o, S_ARB);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i  = 1'b0;
    req_i  = '0;
    #1;
    check_idle_outputs("reset");
    check("reset_res", res_o, 0);
    check("reset_ua", unit_a_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wait_readies(input string tag, input int target, input int budget);
    int i = 0;
    while (n_ready < target && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    check(tag, n_ready, target);
  endtask

  task automatic wait_state(input string tag, input int st, input int budget);
    int i = 0;
    while (int'(state_o) != st && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    check(tag, state_o, st);
  endtask

  task automatic wait_idle(input string tag);
    wait_state(tag, S_ARB, 20);
    @(negedge clk_i);
  endtask

  // ---------------- directed sequence ----------------
  int t0;
  int base;

  initial begin
    rst_i  = 1'b0;
    req_i  = '0;
    mode_i = '0;
    a_i    = '0;
    b_i    = '0;
    do_reset();

    // Single requester, sub 25-16, unit answers 2 cycles after start.
    unit_lat = 1;
    drive_req(0, 1'b1, 1'b0, 8'd25, 8'd16);
    expect_txn(8'd9, 2'b01);
    t0 = cyc;
    @(negedge clk_i);
    check("t1_start", unit_start_o, 1);
    check("t1_grant", grant_o, 2'b01);
    check("t1_state", state_o, S_ISSUE);
    check("t1_busy", busy_o, 1);
    check("t1_ua", unit_a_o, 8'd25);
    check("t1_ub", unit_b_o, 8'd16);
    check("t1_umode", unit_mode_o, 0);
    wait_readies("t1_ready", 1, 20);
    check("t1_latency", last_rdy_cyc - t0, 4);
    drive_req(0, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk_i);
    check("t1_rel_grant", grant_o, 0);
    check("t1_rel_ready", ready_o, 0);
    check("t1_rel_busy", busy_o, 1);
    @(negedge clk_i);
    check_idle_outputs("t1_after");

    // Simultaneous requests right after reset, zero-latency unit.
    do_reset();
    unit_lat = 0;
    drive_req(0, 1'b1, 1'b1, 8'd10, 8'd3);
    drive_req(1, 1'b1, 1'b1, 8'd200, 8'd100);
    expect_txn(8'd13, 2'b01);
    expect_txn(8'd44, 2'b10);
    base = n_ready;
    wait_readies("t2_r0", base + 1, 20);
    drive_req(0, 1'b0, 1'b1, 8'd10, 8'd3);
    wait_readies("t2_r1", base + 2, 20);
    drive_req(1, 1'b0, 1'b1, 8'd200, 8'd100);
    check("t2_gap", last_rdy_cyc - prev_rdy_cyc, 5);
    wait_idle("t2_idle");

    // Continuous contention: six transactions alternate 0,1,0,1,0,1.
    unit_lat = 1;
    drive_req(0, 1'b1, 1'b0, 8'd5, 8'd7);
    drive_req(1, 1'b1, 1'b1, 8'd100, 8'd1);
    for (int i = 0; i < 3; i++) begin
      expect_txn(8'd254, 2'b01);
      expect_txn(8'd101, 2'b10);
    end
    base = n_ready;
    wait_readies("t3_six", base + 6, 80);
    req_i = '0;
    wait_idle("t3_idle");

    // Zero-latency unit: req-to-ready is the 3-cycle minimum.
    unit_lat = 0;
    drive_req(0, 1'b1, 1'b1, 8'd255, 8'd1);
    expect_txn(8'd0, 2'b01);
    t0 = cyc;
    base = n_ready;
    wait_readies("t4_fast", base + 1, 20);
    check("t4_fast_lat", last_rdy_cyc - t0, 3);
    req_i = '0;
    wait_idle("t4_idle0");

    // Slow unit: done 5 cycles after the first WAIT cycle.
    unit_lat = 5;
    drive_req(1, 1'b1, 1'b0, 8'd3, 8'd9);
    expect_txn(8'd250, 2'b10);
    t0 = cyc;
    base = n_ready;
    wait_readies("t4_slow", base + 1, 30);
    check("t4_slow_lat", last_rdy_cyc - t0, 8);
    req_i = '0;
    wait_idle("t4_idle1");

    // Spurious done while idle in ARB.
    base = n_ready;
    @(posedge clk_i);
    #1;
    spur_cnt++;
    repeat (3) @(negedge clk_i);
    check("t5_arb_ready", n_ready, base);
    check("t5_arb_state", state_o, S_ARB);
    check("t5_arb_res_hold", res_o, 8'd250);

    // Spurious done during RELEASE.
    unit_lat = 1;
    drive_req(0, 1'b1, 1'b1, 8'd7, 8'd8);
    expect_txn(8'd15, 2'b01);
    wait_readies("t5_txn", base + 1, 20);
    req_i = '0;
    @(posedge clk_i);
    #1;
    spur_cnt++;
    repeat (3) @(negedge clk_i);
    check("t5_rel_ready", n_ready, base + 1);
    check("t5_rel_state", state_o, S_ARB);
    check("t5_rel_res_hold", res_o, 8'd15);

    // Requester drops req (and scrambles operands) during WAIT.
    unit_lat = 3;
    drive_req(1, 1'b1, 1'b0, 8'd60, 8'd70);
    expect_txn(8'd246, 2'b10);
    base = n_ready;
    wait_state("t5_to_wait", S_WAIT, 10);
    drive_req(1, 1'b0, 1'b1, 8'hAA, 8'h55);
    wait_readies("t5_drop", base + 1, 20);
    repeat (6) @(negedge clk_i);
    check("t5_drop_once", n_ready, base + 1);
    check("t5_drop_state", state_o, S_ARB);

    // Reset asserted during WAIT; the late done must be ignored.
    unit_lat = 4;
    drive_req(0, 1'b1, 1'b1, 8'd1, 8'd1);
    base = n_ready;
    wait_state("t6_to_wait", S_WAIT, 10);
    rst_i = 1'b0;
    req_i = '0;
    #1;
    check_idle_outputs("t6_rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("t6_no_ready", n_ready, base);
    check("t6_state", state_o, S_ARB);

    // After that reset, r1 alone is granted and completes normally.
    unit_lat = 1;
    drive_req(1, 1'b1, 1'b1, 8'd40, 8'd2);
    expect_txn(8'd42, 2'b10);
    @(negedge clk_i);
    check("t6_grant_r1", grant_o, 2'b10);
    wait_readies("t6_r1", base + 1, 20);
    req_i = '0;
    wait_idle("t6_idle");

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
